// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the sequential 8x8 multiplier.
//   - state_e     : controller states (IDLE, MUL, DONE)
//   - OP_W/NIB_W/PROD_W/NSTEPS : operand, nibble, product widths, step count
//   - step_shift(): left shift applied to the partial product of each step
package mul_pkg;

  localparam int OP_W   = 8;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;
  localparam int NSTEPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step order: lo*lo, lo*hi, hi*lo, hi*hi (a nibble first, b nibble second).
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      default: sh = 4'd8;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mul8_seq_bin_mul.sv
// bin_mul: combinational 4x4 unsigned array multiplier.
//   a_i [3:0]  multiplicand nibble
//   b_i [3:0]  multiplier nibble
//   p_o [7:0]  a_i * b_i
// Each set bit of b_i adds a shifted copy of a_i (one row of the array).
module bin_mul
  import mul_pkg::*;
(
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  output logic [2*NIB_W-1:0] p_o
);

  always_comb begin
    p_o = '0;
    for (int i = 0; i < NIB_W; i++) begin
      if (b_i[i]) begin
        p_o = p_o + ((2*NIB_W)'(a_i) << i);
      end
    end
  end

endmodule

// File: rtl/mul8_seq.sv
// mul8_seq: sequential 8x8 unsigned multiplier sharing one 4x4 core over
// four nibble partial products accumulated into a 16-bit result.
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand channel, in_a/in_b operands
//   out_valid/out_ready result channel, product = A*B
//   busy               high while in MUL or DONE
//   dbg_state_o        current controller state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and data until that edge; ready never
// depends combinationally on valid (in_ready/out_valid come from state only).
module mul8_seq
  import mul_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [1:0]          step_q, step_d;

  logic [NIB_W-1:0]    a_nib, b_nib;
  logic [2*NIB_W-1:0]  pp;
  logic [PROD_W-1:0]   pp_shifted;
  logic                op_zero;

  // step[1] picks the a nibble, step[0] the b nibble.
  assign a_nib = step_q[1] ? a_q[7:4] : a_q[3:0];
  assign b_nib = step_q[0] ? b_q[7:4] : b_q[3:0];

  bin_mul u_bin_mul (
    .a_i (a_nib),
    .b_i (b_nib),
    .p_o (pp)
  );

  assign pp_shifted = PROD_W'(pp) << step_shift(step_q);
  assign op_zero    = (in_a == '0) || (in_b == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d    = in_a;
          b_d    = in_b;
          acc_d  = '0;
          step_d = '0;
          state_d = (ZERO_BYPASS && op_zero) ? DONE : MUL;
        end
      end
      MUL: begin
        // Max running sum is 0xFE01, so the 16-bit add never carries out.
        acc_d  = acc_q + pp_shifted;
        step_d = step_q + 2'd1;
        if (step_q == 2'(NSTEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign product     = acc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul8_seq.sv
// tb_mul8_seq: directed and randomized checks of mul8_seq against a
// nibble-arithmetic reference model. A second instance with ZERO_BYPASS=0
// covers the non-bypass zero-operand path.
module tb_mul8_seq;
  import mul_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT wiring ----------------
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic        use_nb = 1'b0;

  logic        d_in_valid, n_in_valid;
  logic        d_in_ready, n_in_ready, d_out_valid, n_out_valid, d_busy, n_busy;
  logic [15:0] d_product, n_product;
  logic [1:0]  d_state, n_state;

  logic        in_ready, out_valid, busy;
  logic [15:0] product;
  logic [1:0]  dbg_state;

  assign d_in_valid = in_valid & ~use_nb;
  assign n_in_valid = in_valid & use_nb;

  always_comb begin
    in_ready  = use_nb ? n_in_ready  : d_in_ready;
    out_valid = use_nb ? n_out_valid : d_out_valid;
    busy      = use_nb ? n_busy      : d_busy;
    product   = use_nb ? n_product   : d_product;
    dbg_state = use_nb ? n_state     : d_state;
  end

  mul8_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(d_out_valid), .out_ready(out_ready),
    .product(d_product), .busy(d_busy), .dbg_state_o(d_state)
  );

  mul8_seq #(.ZERO_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .product(n_product), .busy(n_busy), .dbg_state_o(n_state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Running sum after steps 0..k, from the nibble step schedule.
  function automatic logic [15:0] model_partial(input int a, input int b, input int k);
    int an[4], bn[4], sc[4], sum;
    an[0] = a % 16; an[1] = a % 16; an[2] = a / 16; an[3] = a / 16;
    bn[0] = b % 16; bn[1] = b / 16; bn[2] = b % 16; bn[3] = b / 16;
    sc[0] = 1;      sc[1] = 16;     sc[2] = 16;     sc[3] = 256;
    sum = 0;
    for (int j = 0; j <= k; j++) sum += an[j] * bn[j] * sc[j];
    return 16'(sum);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called at the start of an IDLE cycle; returns after the product is taken.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int hold, input bit bypass_on);
    logic [15:0] exp_p;
    bit short_path;
    short_path = bypass_on && (a == 8'h00 || b == 8'h00);
    check("idle_in_ready", in_ready, 1);
    exp_q.push_back(16'(int'(a) * int'(b)));
    out_ready = (hold == 0);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick;
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    check("accept_in_ready_low", in_ready, 0);
    check("accept_busy", busy, 1);
    if (!short_path) begin
      check("acc_cleared", product, 0);
      for (int k = 0; k < 4; k++) begin
        check("mul_no_valid", out_valid, 0);
        tick;
        check("acc_step", product, model_partial(int'(a), int'(b), k));
      end
    end
    check("done_valid_latency", out_valid, 1);
    exp_p = exp_q.pop_front();
    check("product", product, exp_p);
    for (int i = 0; i < hold; i++) begin
      tick;
      check("bp_valid_held", out_valid, 1);
      check("bp_product_held", product, exp_p);
      check("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    check("back_idle_valid", out_valid, 0);
    check("back_idle_ready", in_ready, 1);
    check("back_idle_busy", busy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [7:0] ra, rb;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    check("rst_state", dbg_state, IDLE);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Directed products
    run_op(8'h12, 8'h34, 0, 1'b1);
    run_op(8'hFF, 8'hFF, 0, 1'b1);
    run_op(8'h00, 8'h37, 0, 1'b1);
    use_nb = 1'b1;
    run_op(8'h00, 8'h37, 0, 1'b0);
    use_nb = 1'b0;
    run_op(8'hA5, 8'h5A, 3, 1'b1);

    // Reset in the middle of step 2
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h80; in_b = 8'h80;
    tick;
    in_valid = 1'b0;
    tick; tick;
    check("midop_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_product", product, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("midrst_no_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    tick;
    check("post_rst_no_valid", out_valid, 0);
    run_op(8'h80, 8'h80, 0, 1'b1);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h0F;
    tick;
    in_a = 8'hF0; in_b = 8'hF0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    check("b2b_first_latency", n, 5);
    check("b2b_first_product", product, 16'h00E1);
    check("b2b_done_no_accept", in_ready, 0);
    n = 0;
    do begin
      tick;
      n++;
    end while (!out_valid && n < 20);
    check("b2b_spacing", n, 6);
    check("b2b_second_product", product, 16'hE100);
    in_valid = 1'b0;
    tick;
    check("b2b_back_idle", in_ready, 1);

    // Randomized operands and backpressure
    for (int t = 0; t < 12; t++) begin
      ra = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run_op(ra, rb, $urandom_range(0, 3), 1'b1);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
